// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared encodings for the two-requester round-robin arbiter: FSM states,
// select values and the datapath width.
package mux2_arb_pkg;
  localparam int DATA_W = 2;

  typedef logic [1:0] state_t;
  localparam state_t IDLE    = 2'd0;
  localparam state_t GRANT_A = 2'd1;
  localparam state_t GRANT_B = 2'd2;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;
endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// Handshake bundle between the two producers, the arbiter and the consumer.
interface mux2_rr_arbiter_if
  import mux2_arb_pkg::*;
();
  logic              a_valid;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              sel;
  logic              busy;

  modport slave (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, out_valid, out_data, sel, busy
  );

  modport master (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, out_valid, out_data, sel, busy
  );
endinterface

// File: rtl/mux2_rr_arbiter_mux2.sv
// Plain 2:1 data select shared by the two requesters (S0=0 picks A).
module mux2
  import mux2_arb_pkg::*;
(
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              S0,
  output logic [DATA_W-1:0] Y
);
  assign Y = S0 ? B : A;
endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter: grants A or B, steers the shared mux and registers the
// chosen beat into a single output stage; a burst counter bounds each grant.
module mux2_rr_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mux2_rr_arbiter_if.slave    bus
);
  localparam int CNT_W = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [DATA_W-1:0] mux_y;
  logic              slot_free, a_rdy, b_rdy, sel, xfer;

  mux2 u_mux (
    .A  (bus.a_data),
    .B  (bus.b_data),
    .S0 (sel),
    .Y  (mux_y)
  );

  // State register, burst counter and output stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= SEL_B;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= mux_y;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Next-state: a stalled grant (valid but no xfer) keeps both state and count
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (state_q)
      GRANT_A: begin
        if (!bus.a_valid) begin
          state_d = bus.b_valid ? GRANT_B : IDLE;
          cnt_d   = '0;
          last_d  = SEL_A;
        end else if (xfer) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (bus.b_valid) begin
              state_d = GRANT_B;
              last_d  = SEL_A;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      GRANT_B: begin
        if (!bus.b_valid) begin
          state_d = bus.a_valid ? GRANT_A : IDLE;
          cnt_d   = '0;
          last_d  = SEL_B;
        end else if (xfer) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (bus.a_valid) begin
              state_d = GRANT_A;
              last_d  = SEL_B;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        if (bus.a_valid && bus.b_valid) begin
          state_d = (last_q == SEL_B) ? GRANT_A : GRANT_B;
        end else if (bus.a_valid) begin
          state_d = GRANT_A;
        end else if (bus.b_valid) begin
          state_d = GRANT_B;
        end
      end
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    slot_free = !out_valid_q || bus.out_ready;
    a_rdy     = (state_q == GRANT_A) && slot_free;
    b_rdy     = (state_q == GRANT_B) && slot_free;
    sel       = (state_q == GRANT_B) ? SEL_B : SEL_A;
    xfer      = (a_rdy && bus.a_valid) || (b_rdy && bus.b_valid);
  end

  assign bus.a_ready   = a_rdy;
  assign bus.b_ready   = b_rdy;
  assign bus.sel       = sel;
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter (HOLD_MAX=4) with hand-computed expectations.
module tb_mux2_rr_arbiter;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  mux2_rr_arbiter_if bus ();

  mux2_rr_arbiter #(.HOLD_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    next_cyc();
    next_cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.a_valid = 1'b1;
    bus.a_data = 2'b00;
    bus.b_valid = 1'b0;
    bus.b_data = 2'b00;
    bus.out_ready = 1'b1;

    // Reset held with a_valid asserted
    next_cyc();
    next_cyc();
    @(negedge clk);
    chk_eq("rst_out_valid", bus.out_valid, 0);
    chk_eq("rst_out_data", bus.out_data, 0);
    chk_eq("rst_a_ready", bus.a_ready, 0);
    chk_eq("rst_b_ready", bus.b_ready, 0);
    chk_eq("rst_sel", bus.sel, 0);
    chk_eq("rst_busy", bus.busy, 0);
    next_cyc();
    rst_n = 1'b1;
    bus.a_valid = 1'b0;
    next_cyc();

    // Single request latency
    bus.a_valid = 1'b1;
    bus.a_data = 2'b10;
    @(negedge clk);
    chk_eq("lat_c0_a_ready", bus.a_ready, 0);
    next_cyc();
    @(negedge clk);
    chk_eq("lat_c1_a_ready", bus.a_ready, 1);
    chk_eq("lat_c1_busy", bus.busy, 1);
    chk_eq("lat_c1_out_valid", bus.out_valid, 0);
    next_cyc();
    bus.a_valid = 1'b0;
    @(negedge clk);
    chk_eq("lat_c2_out_valid", bus.out_valid, 1);
    chk_eq("lat_c2_out_data", bus.out_data, 2);
    next_cyc();
    @(negedge clk);
    chk_eq("lat_c3_busy", bus.busy, 0);
    chk_eq("lat_c3_out_valid", bus.out_valid, 0);

    // Continuous contention: 4 A, 4 B, 4 A with no bubble
    next_cyc();
    do_reset();
    bus.a_valid = 1'b1;
    bus.a_data = 2'b01;
    bus.b_valid = 1'b1;
    bus.b_data = 2'b10;
    @(negedge clk);
    chk_eq("rr_c0_busy", bus.busy, 0);
    next_cyc();
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k <= 12) begin
        chk_eq($sformatf("rr_sel_c%0d", k), bus.sel, ((k - 1) / 4) % 2);
        chk_eq($sformatf("rr_a_ready_c%0d", k), bus.a_ready, (((k - 1) / 4) % 2) == 0);
      end
      if (k >= 2) begin
        chk_eq($sformatf("rr_out_data_c%0d", k), bus.out_data,
               ((((k - 2) / 4) % 2) == 0) ? 1 : 2);
        chk_eq($sformatf("rr_out_valid_c%0d", k), bus.out_valid, 1);
      end
      if (k == 13) begin
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
      end
      next_cyc();
    end

    // Output stall while A is granted
    bus.a_valid = 1'b1;
    bus.a_data = 2'b11;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk_eq("stall_q0_out_valid", bus.out_valid, 0);
    next_cyc();
    @(negedge clk);
    chk_eq("stall_q1_a_ready", bus.a_ready, 1);
    next_cyc();
    bus.a_data = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_eq($sformatf("stall_a_ready_%0d", i), bus.a_ready, 0);
      chk_eq($sformatf("stall_out_data_%0d", i), bus.out_data, 3);
      chk_eq($sformatf("stall_out_valid_%0d", i), bus.out_valid, 1);
      next_cyc();
    end
    bus.out_ready = 1'b1;
    bus.b_valid = 1'b1;
    bus.b_data = 2'b10;
    @(negedge clk);
    chk_eq("stall_q5_a_ready", bus.a_ready, 1);
    next_cyc();
    @(negedge clk);
    chk_eq("stall_q6_sel", bus.sel, 0);
    chk_eq("stall_q6_out_data", bus.out_data, 1);
    next_cyc();
    @(negedge clk);
    chk_eq("stall_q7_sel", bus.sel, 0);
    next_cyc();
    @(negedge clk);
    chk_eq("stall_q8_sel", bus.sel, 1);
    chk_eq("stall_q8_b_ready", bus.b_ready, 1);
    next_cyc();

    // B drops valid while granted: switch to A with one bubble
    bus.b_valid = 1'b0;
    @(negedge clk);
    chk_eq("drop_q9_sel", bus.sel, 1);
    chk_eq("drop_q9_out_data", bus.out_data, 2);
    chk_eq("drop_q9_out_valid", bus.out_valid, 1);
    next_cyc();
    @(negedge clk);
    chk_eq("drop_q10_sel", bus.sel, 0);
    chk_eq("drop_q10_out_valid", bus.out_valid, 0);
    chk_eq("drop_q10_a_ready", bus.a_ready, 1);
    next_cyc();
    @(negedge clk);
    chk_eq("drop_q11_out_valid", bus.out_valid, 1);
    chk_eq("drop_q11_out_data", bus.out_data, 1);
    next_cyc();

    // Reset mid-burst, then tie goes to A
    rst_n = 1'b0;
    bus.b_valid = 1'b1;
    @(negedge clk);
    chk_eq("mid_q12_out_valid", bus.out_valid, 1);
    next_cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk_eq("mid_q13_out_valid", bus.out_valid, 0);
    chk_eq("mid_q13_out_data", bus.out_data, 0);
    chk_eq("mid_q13_busy", bus.busy, 0);
    chk_eq("mid_q13_a_ready", bus.a_ready, 0);
    next_cyc();
    bus.a_data = 2'b10;
    @(negedge clk);
    chk_eq("mid_q14_sel", bus.sel, 0);
    chk_eq("mid_q14_a_ready", bus.a_ready, 1);
    chk_eq("mid_q14_b_ready", bus.b_ready, 0);
    next_cyc();
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    @(negedge clk);
    chk_eq("mid_q15_out_valid", bus.out_valid, 1);
    chk_eq("mid_q15_out_data", bus.out_data, 2);
    next_cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
